// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, LSB first, one start bit, SB_TICKS-tick stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SB_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [NW-1:0] NLast = NW'(DATA_BITS - 1);
  localparam logic [3:0] SLast = 4'(SB_TICKS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e               state_q, state_d;
  logic [3:0]           s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;
  logic                 rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    armed_d = armed_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          // A line must be seen idle before re-arming, so a held break gives one frame.
          if (rx_s_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = StStart;
            s_d     = '0;
          end
        end
        StStart: begin
          if (s_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
        StData: begin
          if (s_q == 4'd15) begin
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            s_d     = '0;
            if (n_q == NLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (s_q == 4'd15) begin
            par_d   = rx_s_q;
            state_d = StStop;
            s_d     = '0;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
`endif
        StStop: begin
          if (s_q == SLast) begin
            state_d = StIdle;
            s_d     = '0;
            dout_d  = shreg_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s_q;
            if (!rx_s_q) armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = ^{shreg_q, par_q};
`endif
          end else begin
            s_d = s_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame.
REQ-002 The block SHALL have parameter SB_TICKS, default 16, meaning the number of oversample ticks in the stop bit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port tick, input, 1 bit: a one-clk pulse at 16x the baud rate.
REQ-006 The block SHALL have port rx, input, 1 bit: the asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_dout, output, DATA_BITS bits: the last received data word.
REQ-008 The block SHALL have port rx_done_tick, output, 1 bit: a one-clk pulse when a frame completes.
REQ-009 The block SHALL have port frame_err, output, 1 bit: the stop bit sampled low; valid only with rx_done_tick.
REQ-010 The block SHALL have port parity_err, output, 1 bit: a parity mismatch; valid only with rx_done_tick.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before use; all references to rx below mean this synchronized value (rx_s).
REQ-012 The FSM states SHALL be IDLE, START, DATA, PARITY and STOP; state, the 4-bit tick counter s and the bit counter n SHALL advance only on cycles with tick=1.
REQ-013 IDLE: when tick=1, armed=1 and rx_s=0, the FSM SHALL go to START with s=0.
REQ-014 START: when s==7, the FSM SHALL go to DATA with s=0 and n=0 if rx_s=0, else it SHALL return to IDLE (glitch reject) with no output activity; otherwise s SHALL increment.
REQ-015 DATA: when s==15, the FSM SHALL shift rx_s into the MSB of the shift register (shift right, LSB first on the line) and set s=0; at n==DATA_BITS-1 it SHALL go to PARITY (macro defined) or STOP; otherwise n SHALL increment.
REQ-016 STOP: when s==SB_TICKS-1, the FSM SHALL go to IDLE; otherwise s SHALL increment.
REQ-017 On the STOP-exit tick, the block SHALL register rx_dout from the shift register, pulse rx_done_tick=1 for exactly one clk cycle, and set frame_err=~rx_s and the parity_err result in that same cycle.
REQ-018 A frame with an error SHALL still update rx_dout and pulse rx_done_tick.
REQ-019 rx_dout SHALL hold its value until the next frame completes.
REQ-020 frame_err and parity_err SHALL be 0 in all cycles where rx_done_tick=0.
REQ-021 armed SHALL clear on a framing error and set on any tick where rx_s=1 while in IDLE, so that a held-low line (break) yields one frame only.
REQ-022 Latency SHALL be rx_done_tick one clk after the tick that ends the stop bit.
REQ-023 The block SHALL have no internal buffering, so an unread rx_dout is overwritten by the next frame.
REQ-024 When tick stays low, all state SHALL hold indefinitely.

Reset
REQ-025 With reset=1 at a clk edge, the block SHALL set state=IDLE, s=0, n=0, shift register=0, rx_dout=0, rx_done_tick=0, frame_err=0, parity_err=0, both synchronizer flops=1 and armed=1.
REQ-026 Reset SHALL override tick.
REQ-027 Reset mid-frame SHALL abort the frame with no rx_done_tick, and reception SHALL restart at the next falling edge after release.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: the block SHALL insert a PARITY state after DATA that samples rx_s at s==15 and checks even parity over the data bits plus the parity bit, with parity_err=1 on mismatch.
REQ-029 Macro UART_RX_PARITY_EN undefined: there SHALL be no PARITY state, DATA SHALL go directly to STOP, and parity_err SHALL be tied to 0 with the port retained.

Verification
REQ-030 The bench SHALL send 0xA5 with 8N1 at 16 ticks per bit -> exactly one rx_done_tick, rx_dout=0xA5, frame_err=0, with the pulse 1 clk after tick #(16*10-8) counted from the start edge.
REQ-031 The bench SHALL drive rx low for 4 ticks and then high -> the FSM returns to IDLE, with no rx_done_tick and rx_dout unchanged.
REQ-032 The bench SHALL send 0x3C with the stop bit low -> rx_done_tick=1, rx_dout=0x3C, frame_err=1; then hold rx low for 40 bit times -> no further rx_done_tick until rx has returned high.
REQ-033 The bench SHALL assert reset during data bit 4 of 0xFF, then send 0x12 -> no pulse for the aborted frame, and rx_dout=0x12 with one rx_done_tick.
REQ-034 With UART_RX_PARITY_EN defined, the bench SHALL send 0x07 with parity bit 1 and then with parity bit 0 -> parity_err=0, then parity_err=1, with rx_dout=0x07 both times.
REQ-035 The bench SHALL send 0x00 followed immediately by 0xFF (back-to-back, no idle gap) -> two pulses, rx_dout=0x00 then rx_dout=0xFF.
